// File: rtl/reg_fifo_alu.sv
// Register-mapped FIFO ALU: operand FIFOs A/B feed a bitwise/add stage into result FIFO Y.
// Optional sticky error flags at read address 7 are built when ALU_ERR_STATUS_EN is defined.

// Generic synchronous FIFO with registered occupancy; head reads 0 when empty.
// Latency: a push is visible at the head on the edge after it is written.
// Backpressure: push ignored when full, pop ignored when empty (both on registered state).
module reg_fifo_alu_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: the head is masked to 0 whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// Top: write port enqueues A/B or sets mode; compute pops one A/B pair per cycle into Y.
// Latency: result pushed into Y one edge after both operands are present; read_data is combinational.
// Backpressure: compute stalls while Y is full; writes to full operand FIFOs are dropped.
module reg_fifo_alu #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [2:0]        write_address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write_en,
    output logic              write_rdy,
    input  logic [2:0]        read_address,
    input  logic              read_en,
    output logic [DATA_W-1:0] read_data,
    output logic              read_rdy,
    output logic [DATA_W-1:0] a_ff_dout,
    output logic [DATA_W-1:0] b_ff_dout,
    output logic [DATA_W-1:0] y_ff_dout
);
    logic              rdy_q;
    logic [1:0]        mode_q;
    logic [1:0]        wr_mode;
    logic              wr_acc;
    logic              rd_acc;
    logic              a_push, b_push, y_pop, fire;
    logic              a_full, a_empty, b_full, b_empty, y_full, y_empty;
    logic [DATA_W-1:0] y_dat;

    assign write_rdy = rdy_q;
    assign read_rdy  = rdy_q;
    assign wr_acc    = write_en && rdy_q;
    assign rd_acc    = read_en && rdy_q;

    assign a_push = wr_acc && (write_address == 3'd4);
    assign b_push = wr_acc && (write_address == 3'd5);
    assign y_pop  = rd_acc && (read_address == 3'd3) && !y_empty;
    assign fire   = !a_empty && !b_empty && !y_full;

    generate
        if (DATA_W >= 2) begin : g_mode_wide
            assign wr_mode = write_data[1:0];
        end else begin : g_mode_narrow
            assign wr_mode = {1'b0, write_data[0]};
        end
    endgenerate

    always_comb begin
        y_dat = '0;
        case (mode_q)
            2'd0: y_dat = a_ff_dout | b_ff_dout;
            2'd1: y_dat = a_ff_dout & b_ff_dout;
            2'd2: y_dat = a_ff_dout ^ b_ff_dout;
            2'd3: y_dat = a_ff_dout + b_ff_dout;
            default: y_dat = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rdy_q  <= 1'b0;
            mode_q <= 2'd0;
        end else begin
            rdy_q <= 1'b1;
            if (wr_acc && (write_address == 3'd6)) mode_q <= wr_mode;
        end
    end

    reg_fifo_alu_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_a_fifo (
        .clk(CLK), .rst_n(RST_N), .push(a_push), .push_dat(write_data),
        .pop(fire), .head_dat(a_ff_dout), .full(a_full), .empty(a_empty)
    );

    reg_fifo_alu_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_b_fifo (
        .clk(CLK), .rst_n(RST_N), .push(b_push), .push_dat(write_data),
        .pop(fire), .head_dat(b_ff_dout), .full(b_full), .empty(b_empty)
    );

    reg_fifo_alu_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_y_fifo (
        .clk(CLK), .rst_n(RST_N), .push(fire), .push_dat(y_dat),
        .pop(y_pop), .head_dat(y_ff_dout), .full(y_full), .empty(y_empty)
    );

`ifdef ALU_ERR_STATUS_EN
    logic [2:0] err_q;
    logic [2:0] err_evt;
    logic       err_clr;

    assign err_evt[0] = a_push && a_full;
    assign err_evt[1] = b_push && b_full;
    assign err_evt[2] = rd_acc && (read_address == 3'd3) && y_empty;
    assign err_clr    = rd_acc && (read_address == 3'd7);

    // An event coinciding with the clear survives it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) err_q <= 3'b0;
        else        err_q <= (err_clr ? 3'b0 : err_q) | err_evt;
    end
`endif

    always_comb begin
        read_data = '0;
        case (read_address)
            3'd0: read_data = DATA_W'(!a_full);
            3'd1: read_data = DATA_W'(!b_full);
            3'd2: read_data = DATA_W'(!y_empty);
            3'd3: read_data = y_ff_dout;
            3'd6: read_data = DATA_W'(mode_q);
`ifdef ALU_ERR_STATUS_EN
            3'd7: read_data = DATA_W'(err_q);
`endif
            default: read_data = '0;
        endcase
    end
endmodule

// File: tb/tb_reg_fifo_alu.sv
// Directed table-driven bench for reg_fifo_alu (DATA_W=8, DEPTH=4).
module tb_reg_fifo_alu;
`ifdef ALU_ERR_STATUS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam int K_W = 0, K_R = 1, K_I = 2, K_D = 3;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [2:0] write_address = '0;
    logic [7:0] write_data = '0;
    logic       write_en = 1'b0;
    logic       write_rdy;
    logic [2:0] read_address = '0;
    logic       read_en = 1'b0;
    logic [7:0] read_data;
    logic       read_rdy;
    logic [7:0] a_ff_dout, b_ff_dout, y_ff_dout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         kind;
        logic [2:0] addr;
        logic [7:0] dat;
        logic [7:0] exp;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [7:0] ey;
    } vec_t;

    vec_t tbl[$];

    reg_fifo_alu #(.DATA_W(8), .DEPTH(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .write_address(write_address), .write_data(write_data),
        .write_en(write_en), .write_rdy(write_rdy),
        .read_address(read_address), .read_en(read_en),
        .read_data(read_data), .read_rdy(read_rdy),
        .a_ff_dout(a_ff_dout), .b_ff_dout(b_ff_dout), .y_ff_dout(y_ff_dout)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic w(input logic [2:0] a, input logic [7:0] d);
        vec_t v = '{K_W, a, d, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl.push_back(v);
    endtask

    task automatic r(input logic [2:0] a, input logic [7:0] e);
        vec_t v = '{K_R, a, 8'h00, e, 8'h00, 8'h00, 8'h00};
        tbl.push_back(v);
    endtask

    task automatic idle();
        vec_t v = '{K_I, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl.push_back(v);
    endtask

    task automatic dbg(input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] ey);
        vec_t v = '{K_D, 3'd0, 8'h00, 8'h00, ea, eb, ey};
        tbl.push_back(v);
    endtask

    // One table entry per clock: drive after the falling edge, compare 1 time unit later.
    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge CLK);
            write_en = 1'b0;
            read_en  = 1'b0;
            if (tbl[i].kind == K_W) begin
                write_en      = 1'b1;
                write_address = tbl[i].addr;
                write_data    = tbl[i].dat;
            end else if (tbl[i].kind == K_R) begin
                read_en      = 1'b1;
                read_address = tbl[i].addr;
            end
            #1;
            if (tbl[i].kind == K_R) begin
                check($sformatf("step%0d rd_addr%0d", i, tbl[i].addr), read_data, tbl[i].exp);
            end else if (tbl[i].kind == K_D) begin
                check($sformatf("step%0d a_head", i), a_ff_dout, tbl[i].ea);
                check($sformatf("step%0d b_head", i), b_ff_dout, tbl[i].eb);
                check($sformatf("step%0d y_head", i), y_ff_dout, tbl[i].ey);
            end
        end
        @(negedge CLK);
        write_en = 1'b0;
        read_en  = 1'b0;
        tbl.delete();
    endtask

    initial begin
        // Reset for three cycles; ready stays low until the first edge after release.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("write_rdy_before_edge", {7'b0, write_rdy}, 8'h00);
        check("read_rdy_before_edge", {7'b0, read_rdy}, 8'h00);
        @(posedge CLK);
        #1;
        check("write_rdy_after_edge", {7'b0, write_rdy}, 8'h01);
        check("read_rdy_after_edge", {7'b0, read_rdy}, 8'h01);

        r(3'd0, 8'h01); r(3'd1, 8'h01); r(3'd2, 8'h00); r(3'd6, 8'h00);
        r(3'd4, 8'h00); r(3'd5, 8'h00);
        // Underflow: Y empty read returns 0 and leaves state alone.
        r(3'd3, 8'h00); r(3'd2, 8'h00); dbg(8'h00, 8'h00, 8'h00);
        r(3'd7, ERR_EN ? 8'h04 : 8'h00); r(3'd7, 8'h00);

        // OR with latency check: Y not empty only after the compute edge.
        w(3'd4, 8'h0F); w(3'd5, 8'hF0); r(3'd2, 8'h00); r(3'd2, 8'h01);
        r(3'd3, 8'hFF); r(3'd2, 8'h00);

        w(3'd6, 8'h01); r(3'd6, 8'h01); w(3'd4, 8'hCC); w(3'd5, 8'hAA); idle(); r(3'd3, 8'h88);
        w(3'd6, 8'h02); w(3'd4, 8'hCC); w(3'd5, 8'hAA); idle(); r(3'd3, 8'h66);
        w(3'd6, 8'h03); r(3'd6, 8'h03); w(3'd4, 8'hC8); w(3'd5, 8'h64); idle(); r(3'd3, 8'h2C);
        // Mode write lands on the same edge the compute fires: old mode (ADD) applies.
        w(3'd4, 8'h01); w(3'd5, 8'h03); w(3'd6, 8'h00); r(3'd3, 8'h04); r(3'd6, 8'h00);
        // Ignored write addresses leave everything unchanged.
        w(3'd0, 8'hFF); w(3'd3, 8'hFF); w(3'd7, 8'hFF); r(3'd6, 8'h00); dbg(8'h00, 8'h00, 8'h00);

        // Overflow: fifth A write is dropped.
        w(3'd4, 8'h11); w(3'd4, 8'h22); w(3'd4, 8'h33); r(3'd0, 8'h01);
        w(3'd4, 8'h44); r(3'd0, 8'h00);
        w(3'd4, 8'h55); r(3'd0, 8'h00); r(3'd1, 8'h01); dbg(8'h11, 8'h00, 8'h00);
        w(3'd5, 8'h08); w(3'd5, 8'h08); w(3'd5, 8'h08); w(3'd5, 8'h08); idle();
        r(3'd2, 8'h01); r(3'd0, 8'h01); dbg(8'h00, 8'h00, 8'h19);
        r(3'd3, 8'h19); r(3'd3, 8'h2A); r(3'd3, 8'h3B); r(3'd3, 8'h4C); r(3'd2, 8'h00);
        r(3'd7, ERR_EN ? 8'h01 : 8'h00); r(3'd7, 8'h00);

        // Back-pressure: six pairs, Y fills at four, two pairs wait in A/B.
        for (int i = 1; i <= 6; i++) begin
            w(3'd4, 8'(i)); w(3'd5, 8'(i << 4));
        end
        idle(); idle();
        r(3'd2, 8'h01); r(3'd0, 8'h01); r(3'd1, 8'h01); dbg(8'h05, 8'h50, 8'h11);
        r(3'd3, 8'h11); r(3'd3, 8'h22); r(3'd3, 8'h33); r(3'd3, 8'h44);
        r(3'd3, 8'h55); r(3'd3, 8'h66); r(3'd2, 8'h00); dbg(8'h00, 8'h00, 8'h00);
        r(3'd7, 8'h00);
        run_tbl();

        // Reset mid-operation discards queued operands and mode.
        w(3'd6, 8'h02); w(3'd4, 8'h77); w(3'd5, 8'h99);
        run_tbl();
        check("pre_reset_a_head", a_ff_dout, 8'h77);
        RST_N = 1'b0;
        #1;
        check("mid_reset_write_rdy", {7'b0, write_rdy}, 8'h00);
        check("mid_reset_read_rdy", {7'b0, read_rdy}, 8'h00);
        check("mid_reset_a_head", a_ff_dout, 8'h00);
        check("mid_reset_b_head", b_ff_dout, 8'h00);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("rerelease_rdy_low", {7'b0, read_rdy}, 8'h00);
        @(posedge CLK);
        #1;
        check("rerelease_rdy_high", {7'b0, write_rdy}, 8'h01);
        r(3'd6, 8'h00); r(3'd2, 8'h00); r(3'd0, 8'h01); r(3'd1, 8'h01);
        idle(); r(3'd2, 8'h00); dbg(8'h00, 8'h00, 8'h00);
        run_tbl();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
